// File: rtl/striping_param.sv
// Byte striper: distributes a serial 8b symbol stream round-robin over the active lanes.
// It keeps framing aligned: STP always starts lane 0, an END group is padded, and SKP is
// broadcast on every active lane. All outputs are registered.
`timescale 1ns/1ps
module striping_param #(
    parameter int unsigned NUM_LANES = 4,
    parameter logic [7:0]  PAD_SYM   = 8'hF7
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [1:0]             lane_mode,
    input  logic                   valid_in,
    input  logic                   k_in,
    input  logic [7:0]             data_in,
    output logic                   ready_out,
    output logic [NUM_LANES*8-1:0] lane_data,
    output logic [NUM_LANES-1:0]   lane_k,
    output logic [NUM_LANES-1:0]   lane_valid,
    output logic                   err_out
);

    localparam int unsigned PtrW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned NW   = $clog2(NUM_LANES) + 1;

    localparam logic [7:0] SymSkp = 8'h1C;
    localparam logic [7:0] SymStp = 8'hFB;
    localparam logic [7:0] SymEnd = 8'hFD;

    typedef enum logic [0:0] {StIdle, StData} state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [NW-1:0]          n_q, n_mode, n_eff;
    logic [NUM_LANES*8-1:0] stg_data_q, stg_data_d;
    logic [NUM_LANES-1:0]   stg_k_q, stg_k_d;
    logic                   pend_q, pend_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [NUM_LANES*8-1:0] lane_data_q;
    logic [NUM_LANES-1:0]   lane_k_q, lane_valid_q;

    logic [NUM_LANES*8-1:0] grp_data, data_mask;
    logic [NUM_LANES-1:0]   grp_k, lane_mask;
    logic                   emit, accept, last, is_skp, is_stp, is_end;
    int unsigned            ptr_i, req_n;

    // Link width: follow lane_mode only at a group/packet boundary, otherwise hold the latched width.
    always_comb begin
        req_n  = 32'd1 << lane_mode;
        n_mode = (req_n > NUM_LANES) ? NW'(NUM_LANES) : NW'(req_n);
        n_eff  = (state_q == StIdle && ptr_q == '0 && !pend_q) ? n_mode : n_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_mask[i]           = (i < int'(n_eff));
            data_mask[8*i +: 8]    = {8{lane_mask[i]}};
        end
    end

    // Next-state, staging and group assembly.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        stg_data_d = stg_data_q;
        stg_k_d    = stg_k_q;
        pend_d     = 1'b0;
        ready_d    = 1'b1;
        err_d      = 1'b0;
        emit       = 1'b0;
        grp_data   = stg_data_q;
        grp_k      = stg_k_q;
        ptr_i      = 32'(ptr_q);
        last       = (ptr_i + 1 == 32'(n_eff));
        accept     = valid_in && ready_q;
        is_skp     = k_in && (data_in == SymSkp);
        is_stp     = k_in && (data_in == SymStp);
        is_end     = k_in && (data_in == SymEnd);

        if (pend_q) begin
            // Deferred SKP broadcast; input is blocked this cycle.
            emit     = 1'b1;
            grp_data = {NUM_LANES{SymSkp}};
            grp_k    = '1;
        end else if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (is_skp || (is_stp && ptr_q != '0)) begin
                        emit = 1'b1;
                        if (ptr_q == '0) begin
                            grp_data = {NUM_LANES{SymSkp}};
                            grp_k    = '1;
                        end else begin
                            // Close the partial group with padding.
                            for (int i = 0; i < NUM_LANES; i++) begin
                                if (i >= int'(ptr_i)) begin
                                    grp_data[8*i +: 8] = PAD_SYM;
                                    grp_k[i]           = 1'b1;
                                end
                            end
                        end
                        if (is_skp) begin
                            ptr_d   = '0;
                            pend_d  = (ptr_q != '0);
                            ready_d = (ptr_q == '0);
                        end else begin
                            stg_data_d[7:0] = data_in;
                            stg_k_d[0]      = 1'b1;
                            ptr_d           = PtrW'(1);
                            state_d         = StData;
                        end
                    end else begin
                        stg_data_d[8*ptr_i +: 8] = data_in;
                        stg_k_d[ptr_i]           = k_in;
                        if (is_stp) state_d = StData;
                        if (last) begin
                            emit     = 1'b1;
                            grp_data = stg_data_d;
                            grp_k    = stg_k_d;
                            ptr_d    = '0;
                        end else begin
                            ptr_d = ptr_q + PtrW'(1);
                        end
                    end
                end
                StData: begin
                    if (is_stp || is_skp) begin
                        err_d = 1'b1;
                    end else begin
                        stg_data_d[8*ptr_i +: 8] = data_in;
                        stg_k_d[ptr_i]           = k_in;
                        if (is_end || last) begin
                            emit     = 1'b1;
                            grp_data = stg_data_d;
                            grp_k    = stg_k_d;
                            ptr_d    = '0;
                        end else begin
                            ptr_d = ptr_q + PtrW'(1);
                        end
                        if (is_end) begin
                            state_d = StIdle;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                if (i > int'(ptr_i)) begin
                                    grp_data[8*i +: 8] = PAD_SYM;
                                    grp_k[i]           = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs; lanes beyond the active width are forced to zero.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            n_q          <= NW'(1);
            stg_data_q   <= '0;
            stg_k_q      <= '0;
            pend_q       <= 1'b0;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
            lane_data_q  <= '0;
            lane_k_q     <= '0;
            lane_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            n_q        <= n_eff;
            stg_data_q <= stg_data_d;
            stg_k_q    <= stg_k_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            if (emit) begin
                lane_data_q  <= grp_data & data_mask;
                lane_k_q     <= grp_k & lane_mask;
                lane_valid_q <= lane_mask;
            end else begin
                lane_valid_q <= '0;
            end
        end
    end

    assign ready_out  = ready_q;
    assign lane_data  = lane_data_q;
    assign lane_k     = lane_k_q;
    assign lane_valid = lane_valid_q;
    assign err_out    = err_q;

endmodule

// File: tb/tb_striping_param.sv
// Bench for striping_param (4 lanes): directed symbol streams, a queue-based group model and
// a per-cycle output compare, plus literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_striping_param;

    logic        clk = 1'b0;
    logic        reset_L;
    logic [1:0]  lane_mode;
    logic        valid_in, k_in;
    logic [7:0]  data_in;
    logic        ready_out, err_out;
    logic [31:0] lane_data;
    logic [3:0]  lane_k, lane_valid;

    int checks   = 0;
    int failures = 0;

    striping_param #(.NUM_LANES(4), .PAD_SYM(8'hF7)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .lane_mode  (lane_mode),
        .valid_in   (valid_in),
        .k_in       (k_in),
        .data_in    (data_in),
        .ready_out  (ready_out),
        .lane_data  (lane_data),
        .lane_k     (lane_k),
        .lane_valid (lane_valid),
        .err_out    (err_out)
    );

    always #5 clk = ~clk;

    // Model state: current group as a list of {k,data}, packet flag, latched width.
    logic [8:0]  m_grp[$];
    bit          m_inpkt = 0;
    int          m_n     = 4;
    int          err_exp = 0;
    logic [31:0] exp_d[$];
    logic [3:0]  exp_k[$], exp_v[$];
    logic [31:0] log_d[$];
    logic [3:0]  log_k[$], log_v[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_emit();
        logic [31:0] d = '0;
        logic [3:0]  k = '0, v = '0;
        for (int i = 0; i < m_n; i++) begin
            if (i < m_grp.size()) begin
                d[8*i +: 8] = m_grp[i][7:0];
                k[i]        = m_grp[i][8];
            end else begin
                d[8*i +: 8] = 8'hF7;
                k[i]        = 1'b1;
            end
            v[i] = 1'b1;
        end
        exp_d.push_back(d); exp_k.push_back(k); exp_v.push_back(v);
        m_grp.delete();
    endfunction

    function automatic void model_accept(input logic k, input logic [7:0] d);
        bit skp = k && d == 8'h1C;
        bit stp = k && d == 8'hFB;
        bit fin = k && d == 8'hFD;
        if (m_grp.size() == 0 && !m_inpkt) m_n = ((1 << lane_mode) > 4) ? 4 : (1 << lane_mode);
        if (!m_inpkt && skp) begin
            if (m_grp.size() > 0) model_emit();
            for (int i = 0; i < m_n; i++) m_grp.push_back({1'b1, 8'h1C});
            model_emit();
        end else if (m_inpkt && (skp || stp)) begin
            err_exp++;
        end else begin
            if (stp && m_grp.size() > 0) model_emit();
            m_grp.push_back({k, d});
            if (stp) m_inpkt = 1;
            if (fin && m_inpkt) begin
                m_inpkt = 0;
                model_emit();
            end else if (m_grp.size() == m_n) begin
                model_emit();
            end
        end
    endfunction

    // Per-cycle compare against the model's queue of expected groups.
    logic [31:0] last_d;
    logic [3:0]  last_k;
    always @(negedge clk) begin
        if (!reset_L) begin
            last_d = '0;
            last_k = '0;
        end else begin
            if (lane_valid != 4'b0) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_group", {28'd0, lane_valid}, 32'd0);
                end else begin
                    chk("grp_data", lane_data, exp_d.pop_front());
                    chk("grp_k", {28'd0, lane_k}, {28'd0, exp_k.pop_front()});
                    chk("grp_valid", {28'd0, lane_valid}, {28'd0, exp_v.pop_front()});
                end
                log_d.push_back(lane_data); log_k.push_back(lane_k); log_v.push_back(lane_valid);
                last_d = lane_data;
                last_k = lane_k;
            end else begin
                chk("hold_data", lane_data, last_d);
                chk("hold_k", {28'd0, lane_k}, {28'd0, last_k});
            end
            if (err_out) begin
                chk("err_expected", 32'(err_exp > 0), 32'd1);
                if (err_exp > 0) err_exp--;
            end
        end
    end

    task automatic send(input logic k, input logic [7:0] d);
        bit ok = 0;
        valid_in = 1'b1; k_in = k; data_in = d;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (ready_out) begin ok = 1; break; end
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
        else model_accept(k, d);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_d.delete(); log_k.delete(); log_v.delete();
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] d,
                           input logic [3:0] k, input logic [3:0] v);
        chk({name, "_data"}, (idx < log_d.size()) ? log_d[idx] : 32'hDEADBEEF, d);
        chk({name, "_k"}, (idx < log_k.size()) ? {28'd0, log_k[idx]} : 32'hDEADBEEF, {28'd0, k});
        chk({name, "_v"}, (idx < log_v.size()) ? {28'd0, log_v[idx]} : 32'hDEADBEEF, {28'd0, v});
    endtask

    initial begin
        reset_L = 1'b0; lane_mode = 2'b10; valid_in = 1'b0; k_in = 1'b0; data_in = 8'h00;
        idle(3);
        reset_L = 1'b1;
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        chk("rst_valid", {28'd0, lane_valid}, 32'd0);

        // Reset mid-packet discards the partial group.
        send(1'b1, 8'hFB); send(1'b0, 8'hAA);
        reset_L = 1'b0;
        m_grp.delete(); m_inpkt = 0;
        @(posedge clk); @(negedge clk);
        chk("midrst_data", lane_data, 32'd0);
        chk("midrst_k", {28'd0, lane_k}, 32'd0);
        chk("midrst_valid", {28'd0, lane_valid}, 32'd0);
        chk("midrst_err", {31'd0, err_out}, 32'd0);
        chk("midrst_ready", {31'd0, ready_out}, 32'd1);
        @(posedge clk); #1;
        reset_L = 1'b1;
        clear_log();
        send(1'b1, 8'hFB); send(1'b0, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33);
        send(1'b1, 8'hFD);
        idle(3);
        chk_log("t1_g0", 0, 32'h332211FB, 4'b0001, 4'b1111);
        chk_log("t1_g1", 1, 32'hF7F7F7FD, 4'b1111, 4'b1111);

        // x4 SKP broadcast in IDLE.
        clear_log();
        repeat (4) send(1'b1, 8'h1C);
        idle(3);
        chk("t2_groups", log_d.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk_log("t2_skp", i, 32'h1C1C1C1C, 4'b1111, 4'b1111);

        // Full packet, no padding.
        clear_log();
        send(1'b1, 8'hFB);
        repeat (6) send(1'b0, 8'hFF);
        send(1'b1, 8'hFD);
        idle(3);
        chk_log("t3_g0", 0, 32'hFFFFFFFB, 4'b0001, 4'b1111);
        chk_log("t3_g1", 1, 32'hFDFFFFFF, 4'b1000, 4'b1111);

        // SKP arriving with a partial group: pad, one-cycle stall, then broadcast.
        send(1'b1, 8'h7C); send(1'b1, 8'h7C); send(1'b1, 8'h1C);
        @(negedge clk);
        chk("t4_ready_low", {31'd0, ready_out}, 32'd0);
        chk("t4_pad_data", lane_data, 32'hF7F77C7C);
        chk("t4_pad_k", {28'd0, lane_k}, 32'hF);
        @(negedge clk);
        chk("t4_ready_back", {31'd0, ready_out}, 32'd1);
        chk("t4_skp_data", lane_data, 32'h1C1C1C1C);
        chk("t4_skp_valid", {28'd0, lane_valid}, 32'hF);
        idle(2);

        // x2, x1 and short x4 packets.
        clear_log();
        lane_mode = 2'b01;
        send(1'b1, 8'hFB); send(1'b0, 8'hAA); send(1'b0, 8'hBB); send(1'b1, 8'hFD);
        idle(3);
        lane_mode = 2'b00;
        send(1'b1, 8'hFB); send(1'b0, 8'hAA); send(1'b0, 8'hBB); send(1'b1, 8'hFD);
        idle(3);
        lane_mode = 2'b10;
        send(1'b1, 8'hFB); send(1'b0, 8'hAA); send(1'b1, 8'hFD);
        idle(3);
        chk_log("x2_g0", 0, 32'h0000AAFB, 4'b0001, 4'b0011);
        chk_log("x2_g1", 1, 32'h0000FDBB, 4'b0010, 4'b0011);
        chk_log("x1_g0", 2, 32'h000000FB, 4'b0001, 4'b0001);
        chk_log("x1_g1", 3, 32'h000000AA, 4'b0000, 4'b0001);
        chk_log("x1_g2", 4, 32'h000000BB, 4'b0000, 4'b0001);
        chk_log("x1_g3", 5, 32'h000000FD, 4'b0001, 4'b0001);
        chk_log("x4_short", 6, 32'hF7FDAAFB, 4'b1101, 4'b1111);

        // Stall mid-packet, then SKP inside packet is an error and is dropped.
        clear_log();
        send(1'b1, 8'hFB); send(1'b0, 8'hAA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_stall_novalid", {28'd0, lane_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(1'b0, 8'hBB); send(1'b0, 8'hCC);
        send(1'b1, 8'h1C);
        @(negedge clk);
        chk("t6_err_pulse", {31'd0, err_out}, 32'd1);
        chk("t6_err_novalid", {28'd0, lane_valid}, 32'd0);
        @(negedge clk);
        chk("t6_err_cleared", {31'd0, err_out}, 32'd0);
        @(posedge clk); #1;
        send(1'b1, 8'hFD);
        idle(3);
        chk_log("t6_g0", 0, 32'hCCBBAAFB, 4'b0001, 4'b1111);
        chk_log("t6_g1", 1, 32'hF7F7F7FD, 4'b1111, 4'b1111);

        idle(3);
        chk("model_drained", exp_d.size(), 32'd0);
        chk("err_drained", err_exp, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
